// File: rtl/asmd_booth_multiplier_pkg.sv
// Shared types for the ASMD Booth multiplier: controller states and Booth step operations.
package asmd_booth_multiplier_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    BoothNop = 2'b00,
    BoothAdd = 2'b01,
    BoothSub = 2'b10
  } booth_op_e;

  // Radix-2 Booth recoding of the multiplier bit pair {Q[0], q_1}.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    booth_op_e op;
    unique case ({q0, q_1})
      2'b01:   op = BoothAdd;
      2'b10:   op = BoothSub;
      default: op = BoothNop;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/asmd_booth_multiplier_datapath.sv
// Booth datapath: M/A/Q/q_1 registers, W+2-bit adder/subtractor and arithmetic right shifter.
module asmd_booth_multiplier_datapath
  import asmd_booth_multiplier_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  booth_op_e          op_i,
  input  logic               mode_i,
  input  logic [Width-1:0]   word0_i,
  input  logic [Width-1:0]   word1_i,
  output logic               q0_o,
  output logic               q_1_o,
  output logic [2*Width-1:0] step_product_o
);

  logic [Width+1:0] m_q, m_d;
  logic [Width+1:0] a_q, a_d;
  logic [Width:0]   q_q, q_d;
  logic             q1_q, q1_d;

  logic [Width+1:0] sum;
  logic [Width+1:0] a_shift;
  logic [Width:0]   q_shift;

  always_comb begin
    unique case (op_i)
      BoothAdd: sum = a_q + m_q;
      BoothSub: sum = a_q - m_q;
      default:  sum = a_q;
    endcase
    a_shift = {sum[Width+1], sum[Width+1:1]};
    q_shift = {sum[0], q_q[Width:1]};
  end

  always_comb begin
    m_d  = m_q;
    a_d  = a_q;
    q_d  = q_q;
    q1_d = q1_q;
    if (load_i) begin
      m_d  = {{2{mode_i & word0_i[Width-1]}}, word0_i};
      q_d  = {mode_i & word1_i[Width-1], word1_i};
      a_d  = '0;
      q1_d = 1'b0;
    end else if (step_i) begin
      a_d  = a_shift;
      q_d  = q_shift;
      q1_d = q_q[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      m_q  <= '0;
      a_q  <= '0;
      q_q  <= '0;
      q1_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      a_q  <= a_d;
      q_q  <= q_d;
      q1_q <= q1_d;
    end
  end

  assign q0_o  = q_q[0];
  assign q_1_o = q1_q;
  // Low 2W bits of {A,Q} after the current step; exact once all W+1 steps are done.
  assign step_product_o = {a_shift[Width-2:0], q_shift};

endmodule

// File: rtl/asmd_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: ASMD controller, iteration counter and output registers.
module asmd_booth_multiplier
  import asmd_booth_multiplier_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WORD_LENGTH-1:0]     word0,
  input  logic [WORD_LENGTH-1:0]     word1,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic                       ready,
  output logic                       done
);

  localparam int unsigned CntW = $clog2(WORD_LENGTH + 1) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WORD_LENGTH);

  state_e                   state_q, state_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [2*WORD_LENGTH-1:0] product_q, product_d;
  logic                     done_q, done_d;

  logic                     load, step, last_step;
  logic                     q0, q_1;
  booth_op_e                op;
  logic [2*WORD_LENGTH-1:0] step_product;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (count_q == LastCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    step  = 1'b0;
    ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        load  = start;
      end
      StRun:   step = 1'b1;
      default: ;
    endcase
  end

  assign op        = booth_decode(q0, q_1);
  assign last_step = step && (count_q == LastCnt);

  // Product and done are captured on the final step, so done is high for the DONE cycle.
  always_comb begin
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    if (load) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + 1'b1;
    end
    if (last_step) begin
      product_d = step_product;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  asmd_booth_multiplier_datapath #(
    .Width (WORD_LENGTH)
  ) u_datapath (
    .clk_i          (clk),
    .reset_i        (reset),
    .load_i         (load),
    .step_i         (step),
    .op_i           (op),
    .mode_i         (signed_mode),
    .word0_i        (word0),
    .word1_i        (word1),
    .q0_o           (q0),
    .q_1_o          (q_1),
    .step_product_o (step_product)
  );

  assign product = product_q;
  assign done    = done_q;

endmodule

// File: tb/tb_asmd_booth_multiplier.sv
// Self-checking bench for asmd_booth_multiplier (W=8) against an integer-arithmetic model.
module tb_asmd_booth_multiplier;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          signed_mode;
  logic [W-1:0]  word0;
  logic [W-1:0]  word1;
  logic [2*W-1:0] product;
  logic          ready;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asmd_booth_multiplier #(
    .WORD_LENGTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .word0       (word0),
    .word1       (word1),
    .product     (product),
    .ready       (ready),
    .done        (done)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(x * y);
  endfunction

  // Starts one op at the current negedge and observes it; index k = sample just before edge N+k.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int done_edge, output int ready_edge, output int done_cnt,
                        output logic [2*W-1:0] prod);
    done_edge  = -1;
    ready_edge = -1;
    done_cnt   = 0;
    prod       = 'x;
    start       = 1'b1;
    word0       = a;
    word1       = b;
    signed_mode = s;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start       = 1'b0;
        word0       = 8'($urandom);
        word1       = 8'($urandom);
        signed_mode = 1'($urandom);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = k;
          prod      = product;
        end
      end
      if (ready === 1'b1) begin
        ready_edge = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    word0 = '0;
    word1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_product: got %h want 0000", product);
    end
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got ready=%b done=%b want ready=1 done=0", ready, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int de, re, dc;
    logic [2*W-1:0] p;
    run_op(8'd255, 8'd255, 1'b0, de, re, dc, p);
    checks++;
    if (p !== 16'hFE01) begin
      errors++;
      $display("FAIL unsigned_ff_ff: got %h want fe01", p);
    end
    checks++;
    if (de !== 10 || re !== 11 || dc !== 1) begin
      errors++;
      $display("FAIL unsigned_timing: got done_edge=%0d ready_edge=%0d strobes=%0d want 10 11 1",
               de, re, dc);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (product !== 16'hFE01 || done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: got product=%h done=%b ready=%b want fe01 0 1",
               product, done, ready);
    end
  endtask

  task automatic test_signed();
    int de, re, dc;
    logic [2*W-1:0] p;
    run_op(8'h80, 8'h80, 1'b1, de, re, dc, p);
    checks++;
    if (p !== 16'h4000 || de !== 10 || re !== 11 || dc !== 1) begin
      errors++;
      $display("FAIL signed_min_min: got %h edges %0d/%0d/%0d want 4000 10/11/1", p, de, re, dc);
    end
    run_op(8'hFD, 8'd5, 1'b1, de, re, dc, p);
    checks++;
    if (p !== 16'hFFF1 || de !== 10 || re !== 11 || dc !== 1) begin
      errors++;
      $display("FAIL signed_m3_x5: got %h edges %0d/%0d/%0d want fff1 10/11/1", p, de, re, dc);
    end
  endtask

  task automatic test_mode_contrast();
    int de, re, dc;
    logic [2*W-1:0] p;
    run_op(8'hFF, 8'h02, 1'b0, de, re, dc, p);
    checks++;
    if (p !== 16'h01FE || de !== 10 || re !== 11) begin
      errors++;
      $display("FAIL mode_unsigned: got %h edges %0d/%0d want 01fe 10/11", p, de, re);
    end
    run_op(8'hFF, 8'h02, 1'b1, de, re, dc, p);
    checks++;
    if (p !== 16'hFFFE || de !== 10 || re !== 11) begin
      errors++;
      $display("FAIL mode_signed: got %h edges %0d/%0d want fffe 10/11", p, de, re);
    end
  endtask

  task automatic test_random();
    int de, re, dc;
    logic [2*W-1:0] p, exp;
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      exp = ref_mul(a, b, s);
      run_op(a, b, s, de, re, dc, p);
      checks++;
      if (p !== exp || de !== 10 || re !== 11 || dc !== 1) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h s=%b got %h edges %0d/%0d/%0d want %h 10/11/1",
                 i, a, b, s, p, de, re, dc, exp);
      end
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  task automatic test_busy();
    int de = -1;
    int re = -1;
    int dc = 0;
    int extra = 0;
    logic [2*W-1:0] p = 'x;
    start = 1'b1;
    word0 = 8'd200;
    word1 = 8'd3;
    signed_mode = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4 || k == 11) start = 1'b0;
      if (k == 3 || k == 10) begin
        start = 1'b1;
        word0 = 8'd9;
        word1 = 8'd9;
      end
      if (done === 1'b1) begin
        dc++;
        if (de < 0) begin
          de = k;
          p  = product;
        end
      end
      if (ready === 1'b1) begin
        re = k;
        break;
      end
    end
    checks++;
    if (p !== 16'd600 || de !== 10 || re !== 11 || dc !== 1) begin
      errors++;
      $display("FAIL busy_ignored: got %h edges %0d/%0d/%0d want 0258 10/11/1", p, de, re, dc);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ready !== 1'b1 || done !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0 || product !== 16'd600) begin
      errors++;
      $display("FAIL busy_not_queued: got %0d busy/done cycles product=%h want 0 and 0258",
               extra, product);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a[3];
    logic [W-1:0] b[3];
    logic         s[3];
    int           dedge[3];
    logic [2*W-1:0] dprod[3];
    int nd = 0;
    int idx = 0;
    for (int i = 0; i < 3; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
      s[i] = 1'($urandom);
      dedge[i] = -1;
      dprod[i] = 'x;
    end
    start = 1'b1;
    word0 = a[0];
    word1 = b[0];
    signed_mode = s[0];
    @(posedge clk);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (nd < 3) begin
          dedge[nd] = k;
          dprod[nd] = product;
        end
        nd++;
      end
      if (ready === 1'b1) begin
        idx++;
        if (idx < 3) begin
          word0 = a[idx];
          word1 = b[idx];
          signed_mode = s[idx];
        end else begin
          start = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (nd !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done strobes want 3", nd);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dedge[i] !== 10 + 11 * i || dprod[i] !== ref_mul(a[i], b[i], s[i])) begin
        errors++;
        $display("FAIL b2b_op%0d: got edge %0d product %h want edge %0d product %h", i,
                 dedge[i], dprod[i], 10 + 11 * i, ref_mul(a[i], b[i], s[i]));
      end
    end
  endtask

  task automatic test_abort();
    int de, re, dc;
    int bad = 0;
    logic [2*W-1:0] p;
    run_op(8'd7, 8'd9, 1'b0, de, re, dc, p);
    start = 1'b1;
    word0 = 8'd100;
    word1 = 8'd100;
    signed_mode = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 4) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (product !== 16'h0000 || ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got product=%h ready=%b done=%b want 0000 1 0",
               product, ready, done);
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d cycles with done or busy want 0", bad);
    end
    run_op(8'd0, 8'hA5, 1'b0, de, re, dc, p);
    checks++;
    if (p !== 16'h0000 || de !== 10 || re !== 11 || dc !== 1) begin
      errors++;
      $display("FAIL abort_next_op: got %h edges %0d/%0d/%0d want 0000 10/11/1", p, de, re, dc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mode_contrast();
    test_random();
    test_busy();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
